// File: rtl/ber_align_tracker.sv
// Symbol-error-rate monitor: finds the tx->rx symbol delay, then counts errors per LFSR period.
// Latency: lock/delay/count outputs update on the deciding strobe's edge; meas_valid is high for the next clk.
// Backpressure: none; all state advances only on sym_clk_en, and the block never stalls its inputs.
module ber_align_tracker #(
    parameter int MAX_DELAY   = 63,
    parameter int WIN_LEN     = 256,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 32,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic             period_mark,
    input  logic [1:0]       tx_data,
    input  logic [1:0]       rx_data,
    output logic             locked,
    output logic [5:0]       delay_sel,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count,
    output logic             meas_valid,
    output logic             meas_full
);

    localparam int WIN_W  = $clog2(WIN_LEN);
    // one extra bit so a window where every symbol is wrong still fits
    localparam int WERR_W = WIN_W + 1;

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0] LOCK_LIM = WERR_W'(LOCK_THRESH);
    localparam logic [WERR_W-1:0] LOSS_LIM = WERR_W'(LOSS_THRESH);
    localparam logic [5:0]        DLY_MAX  = 6'(MAX_DELAY);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        dline_q [1:MAX_DELAY];
    logic [1:0]        dline_d [1:MAX_DELAY];
    logic [1:0]        tap     [0:MAX_DELAY];
    logic [5:0]        delay_sel_q, delay_sel_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0] win_err_q, win_err_d;
    logic [CNT_W-1:0]  p_err_q, p_err_d;
    logic [CNT_W-1:0]  p_sym_q, p_sym_d;
    logic              dirty_q, dirty_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  sym_count_q, sym_count_d;
    logic              meas_valid_q, meas_valid_d;
    logic              meas_full_q, meas_full_d;

    logic              mis;
    logic              win_end;
    logic [WERR_W-1:0] win_err_sum;
    logic [5:0]        delay_next;
    logic [CNT_W-1:0]  p_sym_inc;
    logic [CNT_W-1:0]  p_err_inc;

    // Tap 0 is the live tx symbol; tap k is the symbol seen k strobes ago.
    always_comb begin
        tap[0] = tx_data;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            tap[k] = dline_q[k];
        end
    end

    assign mis         = (rx_data != tap[delay_sel_q]);
    assign win_end     = (win_cnt_q == WIN_LAST);
    // window total including this strobe, so the decision sees the last symbol
    assign win_err_sum = win_err_q + WERR_W'(mis);
    assign delay_next  = (delay_sel_q == DLY_MAX) ? 6'd0 : delay_sel_q + 6'd1;
    assign p_sym_inc   = (&p_sym_q) ? p_sym_q : p_sym_q + CNT_W'(1);
    assign p_err_inc   = (&p_err_q) ? p_err_q : p_err_q + CNT_W'(mis);

    // Next-state: delay line, window counters, search/lock FSM and period latch, all gated by the strobe.
    always_comb begin
        state_d      = state_q;
        dline_d      = dline_q;
        delay_sel_d  = delay_sel_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        p_err_d      = p_err_q;
        p_sym_d      = p_sym_q;
        dirty_d      = dirty_q;
        err_count_d  = err_count_q;
        sym_count_d  = sym_count_q;
        meas_full_d  = meas_full_q;
        meas_valid_d = 1'b0;

        if (sym_clk_en) begin
            dline_d[1] = tx_data;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                dline_d[k] = dline_q[k-1];
            end

            win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
            win_err_d = win_end ? '0 : win_err_sum;

            case (state_q)
                S_SEARCH: begin
                    if (win_end) begin
                        if (win_err_sum <= LOCK_LIM) begin
                            state_d = S_LOCKED;
                            // the period in progress at lock time is only partially observed
                            dirty_d = 1'b1;
                        end else begin
                            delay_sel_d = delay_next;
                        end
                    end
                end
                S_LOCKED: begin
                    p_sym_d = p_sym_inc;
                    p_err_d = p_err_inc;
                    if (period_mark) begin
                        err_count_d  = p_err_inc;
                        sym_count_d  = p_sym_inc;
                        meas_full_d  = ~dirty_q;
                        meas_valid_d = 1'b1;
                        p_err_d      = '0;
                        p_sym_d      = '0;
                        dirty_d      = 1'b0;
                    end
                    // loss is evaluated after the latch so a coincident mark still reports
                    if (win_end && (win_err_sum > LOSS_LIM)) begin
                        state_d     = S_SEARCH;
                        delay_sel_d = delay_next;
                        dirty_d     = 1'b1;
                        p_err_d     = '0;
                        p_sym_d     = '0;
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_SEARCH;
            for (int k = 1; k <= MAX_DELAY; k++) begin
                dline_q[k] <= 2'b00;
            end
            delay_sel_q  <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            p_err_q      <= '0;
            p_sym_q      <= '0;
            dirty_q      <= 1'b0;
            err_count_q  <= '0;
            sym_count_q  <= '0;
            meas_valid_q <= 1'b0;
            meas_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dline_q      <= dline_d;
            delay_sel_q  <= delay_sel_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            p_err_q      <= p_err_d;
            p_sym_q      <= p_sym_d;
            dirty_q      <= dirty_d;
            err_count_q  <= err_count_d;
            sym_count_q  <= sym_count_d;
            meas_valid_q <= meas_valid_d;
            meas_full_q  <= meas_full_d;
        end
    end

    assign locked     = (state_q == S_LOCKED);
    assign delay_sel  = delay_sel_q;
    assign err_count  = err_count_q;
    assign sym_count  = sym_count_q;
    assign meas_valid = meas_valid_q;
    assign meas_full  = meas_full_q;

endmodule

// File: tb/tb_ber_align_tracker.sv
// Directed bench for ber_align_tracker: delay search, lock, period measurement, loss/relock, wrap, reset.
// Strobes every other clk; measurement expectations are queued when the period_mark strobe is driven.
// A negedge monitor pops one expectation per meas_valid pulse and compares the latched counts.
module tb_ber_align_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_clk_en;
    logic        period_mark;
    logic [1:0]  tx_data;
    logic [1:0]  rx_data;
    logic        locked;
    logic [5:0]  delay_sel;
    logic [23:0] err_count;
    logic [23:0] sym_count;
    logic        meas_valid;
    logic        meas_full;

    ber_align_tracker dut (
        .clk        (clk),
        .reset      (rst),
        .sym_clk_en (sym_clk_en),
        .period_mark(period_mark),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .locked     (locked),
        .delay_sel  (delay_sel),
        .err_count  (err_count),
        .sym_count  (sym_count),
        .meas_valid (meas_valid),
        .meas_full  (meas_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] err;
        logic [23:0] sym;
        logic        full;
    } meas_t;

    int          tests = 0;
    int          fails = 0;
    meas_t       exp_q[$];
    meas_t       mon_e;
    logic [15:0] lfsr = 16'hACE1;
    logic [1:0]  hist [0:63];
    int          n;
    int          true_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (strobe %0d)", tag, obs, expv, n);
        end
    endtask

    task automatic lfsr_step();
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 64; k++) hist[k] = 2'b00;
    endtask

    // One symbol: rx is tx delayed by true_d symbols, optionally corrupted.
    task automatic strobe(input logic pm, input logic inj);
        @(negedge clk);
        @(negedge clk);
        for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = lfsr[1:0];
        lfsr_step();
        lfsr_step();
        tx_data     = hist[0];
        rx_data     = hist[true_d] ^ {1'b0, inj};
        period_mark = pm;
        sym_clk_en  = 1'b1;
        @(posedge clk);
        #1;
        sym_clk_en  = 1'b0;
        period_mark = 1'b0;
        n++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"},     locked,     0);
        check({tag, "_delay_sel"},  delay_sel,  0);
        check({tag, "_err_count"},  err_count,  0);
        check({tag, "_sym_count"},  sym_count,  0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_meas_full"},  meas_full,  0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_hist();
        n = 0;
    endtask

    // Error-free acquisition at delay 5 from reset: one delay step per 256-symbol window.
    task automatic acquire5(input string tag);
        true_d = 5;
        while (n < 1536) begin
            strobe(1'b0, 1'b0);
            if ((n % 256) == 0 && n <= 1280) begin
                check({tag, "_search_delay"}, delay_sel, n / 256);
                check({tag, "_search_unlocked"}, locked, 0);
            end
            if (n == 1535) check({tag, "_not_yet_locked"}, locked, 0);
        end
        check({tag, "_locked"}, locked, 1);
        check({tag, "_lock_delay"}, delay_sel, 5);
    endtask

    // Each meas_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL meas_unexpected: observed pulse err=%0d sym=%0d, required none", err_count, sym_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("meas_err_count", err_count, mon_e.err);
                check("meas_sym_count", sym_count, mon_e.sym);
                check("meas_full",      meas_full, mon_e.full);
            end
        end
    end

    initial begin
        int   m;
        logic pm;
        logic inj;

        rst         = 1'b1;
        sym_clk_en  = 1'b0;
        period_mark = 1'b0;
        tx_data     = 2'b00;
        rx_data     = 2'b00;
        true_d      = 5;
        n           = 0;
        clear_hist();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Acquisition from reset
        acquire5("acq");

        // Periods, forced errors, realignment to delay 9, idle toggling while locked
        while (n < 6600) begin
            m   = n + 1;
            pm  = (m > 1536) && (((m - 1536) % 1000) == 0);
            inj = (m == 2600) || (m == 2700) || (m == 2800);
            if (m == 3585) true_d = 9;
            if (m == 2536) exp_q.push_back('{err: 24'd0, sym: 24'd1000, full: 1'b0});
            if (m == 3536) exp_q.push_back('{err: 24'd3, sym: 24'd1000, full: 1'b1});
            if (m == 5536) exp_q.push_back('{err: 24'd0, sym: 24'd672,  full: 1'b0});
            if (m == 6536) exp_q.push_back('{err: 24'd0, sym: 24'd1000, full: 1'b1});
            strobe(pm, inj);
            case (n)
                3584: begin
                    check("p2_still_locked", locked, 1);
                    check("p2_delay", delay_sel, 5);
                end
                3839: check("loss_not_before_window_end", locked, 1);
                3840: begin
                    check("loss_locked", locked, 0);
                    check("loss_delay", delay_sel, 6);
                    check("loss_err_hold", err_count, 3);
                    check("loss_sym_hold", sym_count, 1000);
                end
                4096: check("resrch_delay7", delay_sel, 7);
                4352: check("resrch_delay8", delay_sel, 8);
                4608: begin
                    check("resrch_delay9", delay_sel, 9);
                    check("resrch_unlocked", locked, 0);
                    check("resrch_err_hold", err_count, 3);
                end
                4864: begin
                    check("relock_locked", locked, 1);
                    check("relock_delay", delay_sel, 9);
                    check("relock_err_hold", err_count, 3);
                end
                5600: begin
                    repeat (100) begin
                        @(negedge clk);
                        rx_data     = 2'($urandom);
                        tx_data     = 2'($urandom);
                        period_mark = 1'($urandom);
                    end
                    period_mark = 1'b0;
                    check("idle_locked", locked, 1);
                end
                6536: check("p6_locked", locked, 1);
                default: ;
            endcase
        end

        // Reset while locked, then the same acquisition again
        do_reset("midrst");
        acquire5("reacq");

        // Forced failures push the search past the true delay 2 until it wraps
        do_reset("wrap_rst");
        true_d = 2;
        while (n < 17152) begin
            m   = n + 1;
            inj = (((m - 1) / 256) >= 2) && (((m - 1) / 256) <= 63) && (((m - 1) % 256) < 40);
            strobe(1'b0, inj);
            if ((n % 256) == 0 && n <= 16896) begin
                check("wrap_delay", delay_sel, (n / 256) % 64);
                check("wrap_unlocked", locked, 0);
            end
        end
        check("wrap_relocked", locked, 1);
        check("wrap_relock_delay", delay_sel, 2);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
